// File: rtl/score_controller_if.sv
// Player/collision events in, score and display data out.
// Event inputs are single-cycle pulses sampled on posedge clk; there is no backpressure.
interface score_controller_if;
    logic        start;
    logic        pause;
    logic        collide;
    logic        bonus;
    logic        show_high;
    logic [23:0] score_bcd;
    logic [23:0] high_bcd;
    logic [23:0] disp_bcd;
    logic        tick;
    logic [1:0]  state;

    modport master (
        output start, pause, collide, bonus, show_high,
        input  score_bcd, high_bcd, disp_bcd, tick, state
    );

    modport slave (
        input  start, pause, collide, bonus, show_high,
        output score_bcd, high_bcd, disp_bcd, tick, state
    );
endinterface

// File: rtl/score_controller.sv
// Game sequencer: idle/run/pause/over FSM, score tick divider and a
// saturating 6-digit BCD score with high-score tracking.
module score_controller #(
    parameter int         TICK_DIV = 50000000,
    parameter logic [7:0] BONUS    = 8'h05
) (
    input  logic                  clk,
    input  logic                  reset,
    score_controller_if.slave     bus
);
    localparam int             DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [23:0]     score_q, score_d;
    logic [23:0]     high_q, high_d;
    logic            tick_w;

    // Addend is at most two digits plus carry-in, so one ripple pass is enough;
    // a carry out of the top digit pins the result at 999999.
    function automatic logic [23:0] bcd_add(input logic [23:0] a,
                                            input logic [7:0]  b,
                                            input logic        cin);
        logic [23:0] r;
        logic [23:0] bx;
        logic [4:0]  s;
        logic        c;
        r  = '0;
        bx = {16'd0, b};
        c  = cin;
        for (int i = 0; i < 6; i++) begin
            s = {1'b0, a[i*4 +: 4]} + {1'b0, bx[i*4 +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = s[3:0];
        end
        return c ? 24'h999999 : r;
    endfunction

    assign tick_w = (state_q == RUN) && (div_q == DIV_LAST) && !bus.collide && !bus.pause;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        score_d = score_q;
        high_d  = high_q;
        case (state_q)
            IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    state_d = RUN;
                    score_d = '0;
                end
            end
            RUN: begin
                if (bus.collide) begin
                    state_d = OVER;
                    div_d   = '0;
                    if (score_q > high_q) high_d = score_q;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else begin
                    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
                    score_d = bcd_add(score_q, bus.bonus ? BONUS : 8'h00, tick_w);
                end
            end
            PAUSE: begin
                if (bus.pause) state_d = RUN;
            end
            OVER: begin
                div_d = '0;
                if (bus.start) begin
                    state_d = RUN;
                    score_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            score_q <= '0;
            high_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            score_q <= score_d;
            high_q  <= high_d;
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = high_q;
    assign bus.disp_bcd  = bus.show_high ? high_q : score_q;
    assign bus.tick      = tick_w;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with TICK_DIV=4, BONUS=05 and a score scoreboard.
module tb_score_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    score_controller_if bus ();

    score_controller #(.TICK_DIV(4), .BONUS(8'h05)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    int  m_score;
    int  m_div;
    bit  m_run;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk(tag, bus.score_bcd, exp_q.pop_front());
        end
    endtask

    // Reference behaviour of one idle-input cycle: tick on the last divider count.
    task automatic model_step();
        if (m_run) begin
            if (m_div == 3) m_score = (m_score >= 999999) ? 999999 : m_score + 1;
            m_div = (m_div + 1) % 4;
        end
    endtask

    task automatic run_n(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            model_step();
            exp_q.push_back(to_bcd(m_score));
            cyc();
            sb_check(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.pause = 0; bus.collide = 0; bus.bonus = 0; bus.show_high = 0;
        m_score = 0; m_div = 0; m_run = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 24'(bus.state), 24'(2'b00));
        chk("rst_score", bus.score_bcd, 24'h000000);
        chk("rst_high", bus.high_bcd, 24'h000000);
        chk("rst_tick", 24'(bus.tick), 24'd0);
        reset = 1'b1;
        cyc();

        // T1: start, ticks every 4th cycle
        bus.start = 1; cyc(); bus.start = 0;
        m_run = 1; m_div = 0; m_score = 0;
        chk("t1_state_run", 24'(bus.state), 24'(2'b01));
        run_n(3, "t1_pre");
        chk("t1_tick_high", 24'(bus.tick), 24'd1);
        run_n(33, "t1_count");

        // T2: bonus coincident with tick at 9
        run_n(3, "t2_pre");
        chk("t2_tick_high", 24'(bus.tick), 24'd1);
        bus.bonus = 1;
        exp_q.push_back(24'h000015);
        cyc(); bus.bonus = 0;
        sb_check("t2_bonus_tick");
        m_score = 15; m_div = 0;

        // T3: pause at div=2, hold, resume
        run_n(2, "t3_pre");
        bus.pause = 1;
        exp_q.push_back(24'h000015);
        cyc(); bus.pause = 0;
        sb_check("t3_pause_edge");
        chk("t3_state_pause", 24'(bus.state), 24'(2'b10));
        m_run = 0;
        run_n(10, "t3_frozen");
        chk("t3_still_pause", 24'(bus.state), 24'(2'b10));
        bus.pause = 1; cyc(); bus.pause = 0;
        m_run = 1;
        chk("t3_state_resume", 24'(bus.state), 24'(2'b01));
        run_n(1, "t3_resume1");
        chk("t3_tick_resume", 24'(bus.tick), 24'd1);
        run_n(1, "t3_resume2");
        chk("t3_score16", bus.score_bcd, 24'h000016);

        // T4: collide coincident with tick at 42
        run_n(104, "t4_count");
        run_n(3, "t4_pre");
        chk("t4_tick_before", 24'(bus.tick), 24'd1);
        bus.collide = 1; #1;
        chk("t4_tick_masked", 24'(bus.tick), 24'd0);
        cyc(); bus.collide = 0;
        m_run = 0;
        chk("t4_state_over", 24'(bus.state), 24'(2'b11));
        chk("t4_score", bus.score_bcd, 24'h000042);
        chk("t4_high", bus.high_bcd, 24'h000042);
        bus.show_high = 1; #1;
        chk("t4_disp_high", bus.disp_bcd, 24'h000042);

        // T5: new game, start mid-run ignored, lower score keeps high
        bus.start = 1; cyc(); bus.start = 0;
        m_run = 1; m_div = 0; m_score = 0;
        chk("t5_state_run", 24'(bus.state), 24'(2'b01));
        chk("t5_score_clear", bus.score_bcd, 24'h000000);
        chk("t5_high_kept", bus.disp_bcd, 24'h000042);
        bus.show_high = 0;
        run_n(20, "t5_count_a");
        bus.start = 1;
        model_step();
        exp_q.push_back(to_bcd(m_score));
        cyc(); bus.start = 0;
        sb_check("t5_start_ignored");
        run_n(19, "t5_count_b");
        chk("t5_state_still_run", 24'(bus.state), 24'(2'b01));
        bus.collide = 1; cyc(); bus.collide = 0;
        m_run = 0;
        chk("t5_state_over", 24'(bus.state), 24'(2'b11));
        chk("t5_score", bus.score_bcd, 24'h000010);
        chk("t5_high", bus.high_bcd, 24'h000042);
        chk("t5_disp_score", bus.disp_bcd, 24'h000010);
        bus.show_high = 1; #1;
        chk("t5_disp_high", bus.disp_bcd, 24'h000042);
        bus.show_high = 0;

        // T6: saturation near 999999, then async reset mid-run
        bus.start = 1; cyc(); bus.start = 0;
        bus.pause = 1; cyc(); bus.pause = 0;
        chk("t6_state_pause", 24'(bus.state), 24'(2'b10));
        force dut.score_q = 24'h999998;
        #1;
        release dut.score_q;
        #1;
        chk("t6_preload", bus.score_bcd, 24'h999998);
        @(posedge clk); #1;
        bus.pause = 1; cyc(); bus.pause = 0;
        chk("t6_state_run", 24'(bus.state), 24'(2'b01));
        bus.bonus = 1; cyc(); bus.bonus = 0;
        chk("t6_saturate", bus.score_bcd, 24'h999999);
        m_run = 1; m_div = 1; m_score = 999999;
        run_n(8, "t6_hold_max");
        bus.bonus = 1; cyc(); bus.bonus = 0;
        chk("t6_bonus_at_max", bus.score_bcd, 24'h999999);
        #2 reset = 1'b0;
        #1;
        chk("t6_arst_state", 24'(bus.state), 24'(2'b00));
        chk("t6_arst_score", bus.score_bcd, 24'h000000);
        chk("t6_arst_high", bus.high_bcd, 24'h000000);
        chk("t6_arst_tick", 24'(bus.tick), 24'd0);
        chk("t6_arst_disp", bus.disp_bcd, 24'h000000);
        reset = 1'b1;
        cyc();

        // IDLE ignores everything except start
        bus.bonus = 1; bus.pause = 1; bus.collide = 1; cyc();
        bus.bonus = 0; bus.pause = 0; bus.collide = 0;
        chk("idle_ignore_state", 24'(bus.state), 24'(2'b00));
        chk("idle_ignore_score", bus.score_bcd, 24'h000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
